// File: rtl/serial_in_if.sv
// Purpose: host serial pins plus the SRAM write bus for the serial loader.
// Latency: none (signal bundle only).
// Backpressure: none; SRAM accepts every wen pulse, host pacing is open-loop.
interface serial_in_if;
  // host side (asynchronous to clk)
  logic        sSCLK;
  logic        sMOSI;
  logic        sSS;
  // SRAM write side
  logic        wen;
  logic [15:0] addr;
  logic [15:0] wdata;

  // loader drives the SRAM bus and listens to the host pins
  modport master (
    input  sSCLK,
    input  sMOSI,
    input  sSS,
    output wen,
    output addr,
    output wdata
  );

  // host/SRAM model view
  modport slave (
    output sSCLK,
    output sMOSI,
    output sSS,
    input  wen,
    input  addr,
    input  wdata
  );
endinterface

// File: rtl/serial_in.sv
// Purpose: SPI-style host loader, assembles 16-bit words and writes them to SRAM; optional checksum via SERIAL_IN_CHECKSUM_EN.
// Latency: wen/wdata/addr one clk after the synchronized 16th sSCLK rise (pins to strobe ~3 clk).
// Backpressure: none; host must keep sSCLK phases >= 3 clk, the SRAM takes one write per word.
module serial_in #(
  parameter logic [15:0] LAST_ADDR = 16'hffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  serial_in_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam logic [2:0] ST_ARM   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FULL  = 3'd4;

  // synchronizer and edge-detect state
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic ss_s1_q, ss_s1_d, ss_s2_q, ss_s2_d;
  logic [1:0] warm_q, warm_d;

  // control / datapath state
  logic [2:0]  state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        done_q, done_d;

  logic sclk_rise;

  // Two-flop synchronizers; warm counts the cycles until the reset-time
  // idle values have been flushed out and ss_s2 reflects the real pin.
  always_comb begin
    sclk_s1_d   = bus.sSCLK;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    mosi_s1_d   = bus.sMOSI;
    mosi_s2_d   = mosi_s1_q;
    ss_s1_d     = bus.sSS;
    ss_s2_d     = ss_s1_q;
    warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
  end

  // Synchronizer registers, reset to the idle bus state (sSCLK 0, sSS 1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      warm_q      <= 2'd0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      ss_s1_q     <= ss_s1_d;
      ss_s2_q     <= ss_s2_d;
      warm_q      <= warm_d;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;

  // Frame FSM: shift bits, emit one write per 16 bits, stop at LAST_ADDR.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    done_d  = done_q;
    case (state_q)
      ST_ARM: begin
        // the stale reset value of ss_s2 must not count as a deassert,
        // otherwise a frame cut by reset would be picked up mid-word
        if (warm_q == 2'd2 && ss_s2_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ss_s2_q) begin
          if (en) begin
            state_d = ST_SHIFT;
            cnt_d   = 4'd0;
            shreg_d = 16'd0;
            addr_d  = 16'd0;
            done_d  = 1'b0;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_SHIFT: begin
        // deassert is checked first so it wins over a coincident 16th edge
        if (ss_s2_q) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], mosi_s2_q};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_WRITE;
            wen_d   = 1'b1;
            wdata_d = {shreg_q[14:0], mosi_s2_q};
          end
        end
      end
      ST_WRITE: begin
        // the write is already on the bus this cycle; decide what follows
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = ss_s2_q ? ST_IDLE : ST_FULL;
        end else begin
          addr_d  = addr_q + 16'd1;
          state_d = ss_s2_q ? ST_IDLE : ST_SHIFT;
        end
      end
      ST_FULL: begin
        if (ss_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ARM;
      shreg_q <= 16'd0;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
    end
  end

  assign bus.wen   = wen_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
  assign done      = done_q;

`ifdef SERIAL_IN_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
  logic        frame_start;

  assign frame_start = (state_q == ST_IDLE) && !ss_s2_q && en;

  // Running mod-2^16 sum of written words, restarted with each accepted frame.
  always_comb begin
    csum_d = csum_q;
    if (frame_start)  csum_d = 16'd0;
    else if (wen_q)   csum_d = csum_q + wdata_q;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!rst) csum_q <= 16'd0;
    else      csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_serial_in.sv
// Purpose: directed table-driven bench for serial_in (LAST_ADDR=3) plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_in;
  logic        clk;
  logic        rst;
  logic        en;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  serial_in_if bus();

  serial_in #(.LAST_ADDR(16'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

`ifdef SERIAL_IN_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] wr_q[$];
  logic        prev_wen = 1'b0;

  // capture writes; a strobe lasting two cycles is itself a miscompare
  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      wr_q.push_back({bus.addr, bus.wdata});
      if (prev_wen === 1'b1) begin
        n_miss++;
        $display("FAIL wen_double: wen high two cycles running at addr %h", bus.addr);
      end
    end
    prev_wen = bus.wen;
  end

  typedef struct {
    string          name;
    logic           en;
    logic           drop_en;
    int             nwords;
    logic [5:0][15:0] w;
    int             npart;
    logic [15:0]    part;
    logic           exp_busy;
    int             exp_nwr;
    logic           exp_done;
    logic [15:0]    exp_addr;
    logic [15:0]    exp_csum;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sMOSI = b;
    bus.sSCLK = 1'b0;
    repeat (4) @(negedge clk);
    bus.sSCLK = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) send_bit(w[b]);
  endtask

  task automatic frame_begin(input logic e);
    wr_q.delete();
    en = e;
    bus.sSS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    bus.sSS = 1'b1;
    bus.sSCLK = 1'b0;
    repeat (8) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic check_writes(input string name, input int n, input logic [5:0][15:0] w);
    check({name, "_nwr"}, wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size()) begin
        check({name, "_addr"}, {16'd0, wr_q[i][31:16]}, i);
        check({name, "_data"}, {16'd0, wr_q[i][15:0]}, {16'd0, w[i]});
      end
    end
  endtask

  initial begin
    logic [15:0] tmp;
    logic [5:0][15:0] ww;

    tbl[0] = '{name:"two_words", en:1'b1, drop_en:1'b1, nwords:2,
               w:{16'h0, 16'h0, 16'h0, 16'h0, 16'hABCD, 16'h1234}, npart:0, part:16'h0,
               exp_busy:1'b1, exp_nwr:2, exp_done:1'b0, exp_addr:16'd2, exp_csum:16'hBE01};
    tbl[1] = '{name:"csum_wrap", en:1'b1, drop_en:1'b0, nwords:2,
               w:{16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'hFFFF}, npart:0, part:16'h0,
               exp_busy:1'b1, exp_nwr:2, exp_done:1'b0, exp_addr:16'd2, exp_csum:16'h0001};
    tbl[2] = '{name:"en_low", en:1'b0, drop_en:1'b0, nwords:2,
               w:{16'h0, 16'h0, 16'h0, 16'h0, 16'hAAAA, 16'h5555}, npart:0, part:16'h0,
               exp_busy:1'b0, exp_nwr:0, exp_done:1'b0, exp_addr:16'd2, exp_csum:16'h0001};
    tbl[3] = '{name:"partial", en:1'b1, drop_en:1'b0, nwords:1,
               w:{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00FF}, npart:9, part:16'hA5C3,
               exp_busy:1'b1, exp_nwr:1, exp_done:1'b0, exp_addr:16'd1, exp_csum:16'h00FF};
    tbl[4] = '{name:"full", en:1'b1, drop_en:1'b0, nwords:6,
               w:{16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, npart:0, part:16'h0,
               exp_busy:1'b1, exp_nwr:4, exp_done:1'b1, exp_addr:16'd3, exp_csum:16'h000A};

    // reset state
    rst = 1'b0;
    en = 1'b1;
    bus.sSS = 1'b1;
    bus.sSCLK = 1'b0;
    bus.sMOSI = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wen", {31'd0, bus.wen}, 0);
    check("rst_addr", {16'd0, bus.addr}, 0);
    check("rst_wdata", {16'd0, bus.wdata}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_csum", {16'd0, checksum}, 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      frame_begin(tbl[v].en);
      for (int i = 0; i < tbl[v].nwords; i++) begin
        tmp = tbl[v].w[i];
        for (int b = 15; b >= 0; b--) begin
          send_bit(tmp[b]);
          if (i == 0 && b == 15) begin
            check({tbl[v].name, "_busy_mid"}, {31'd0, busy}, {31'd0, tbl[v].exp_busy});
            if (tbl[v].drop_en) en = 1'b0;
          end
        end
      end
      tmp = tbl[v].part;
      for (int b = 0; b < tbl[v].npart; b++) send_bit(tmp[15 - b]);
      frame_end();
      check_writes(tbl[v].name, tbl[v].exp_nwr, tbl[v].w);
      check({tbl[v].name, "_busy_end"}, {31'd0, busy}, 0);
      check({tbl[v].name, "_done"}, {31'd0, done}, {31'd0, tbl[v].exp_done});
      check({tbl[v].name, "_addr_end"}, {16'd0, bus.addr}, {16'd0, tbl[v].exp_addr});
      check({tbl[v].name, "_csum"}, {16'd0, checksum}, CSUM_ON ? {16'd0, tbl[v].exp_csum} : 32'd0);
    end

    // sSS rises together with the 16th sSCLK edge: word dropped
    ww = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1111};
    frame_begin(1'b1);
    check("restart_done_clr", {31'd0, done}, 0);
    send_word(16'h1111);
    tmp = 16'h7777;
    for (int b = 15; b >= 1; b--) send_bit(tmp[b]);
    bus.sMOSI = tmp[0];
    bus.sSCLK = 1'b0;
    repeat (4) @(negedge clk);
    bus.sSCLK = 1'b1;
    bus.sSS = 1'b1;
    repeat (8) @(negedge clk);
    check_writes("tie", 1, ww);
    check("tie_csum", {16'd0, checksum}, CSUM_ON ? 32'h1111 : 32'd0);
    frame_end();

    // sSS rises during the WRITE cycle: write still lands
    ww = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2222};
    frame_begin(1'b1);
    tmp = 16'h2222;
    for (int b = 15; b >= 1; b--) send_bit(tmp[b]);
    bus.sMOSI = tmp[0];
    bus.sSCLK = 1'b0;
    repeat (4) @(negedge clk);
    bus.sSCLK = 1'b1;
    @(negedge clk);
    bus.sSS = 1'b1;
    repeat (8) @(negedge clk);
    check_writes("ss_in_write", 1, ww);
    check("ss_in_write_busy", {31'd0, busy}, 0);
    frame_end();

    // reset mid-frame: no reception until sSS seen high then low
    frame_begin(1'b1);
    tmp = 16'hF0F0;
    for (int b = 15; b >= 9; b--) send_bit(tmp[b]);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("midrst_wdata", {16'd0, bus.wdata}, 0);
    check("midrst_addr", {16'd0, bus.addr}, 0);
    for (int b = 8; b >= 0; b--) send_bit(tmp[b]);
    send_word(16'h5A5A);
    check("midrst_nwr", wr_q.size(), 0);
    check("midrst_busy", {31'd0, busy}, 0);
    frame_end();
    ww = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C3C};
    frame_begin(1'b1);
    send_word(16'h3C3C);
    frame_end();
    check_writes("after_rst", 1, ww);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/serial_in.md
SERIAL_IN -- requirements
Module: serial_in

Interface
REQ-001 Parameter: LAST_ADDR, default 16'hffff, final SRAM word address of a full load.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-low reset.
REQ-004 Port: en  input  1  frame-accept enable; parent drives low while the flash loader owns the SRAM.
REQ-005 Port: sSCLK  input  1  host serial clock, asynchronous to clk.
REQ-006 Port: sMOSI  input  1  host serial data, MSB first, sampled on sSCLK rising edge.
REQ-007 Port: sSS  input  1  host frame select, active low, asynchronous.
REQ-008 Port: wen  output  1  SRAM write strobe, one-cycle pulse.
REQ-009 Port: addr  output  16  SRAM write address.
REQ-010 Port: wdata  output  16  SRAM write data.
REQ-011 Port: busy  output  1  high while a frame is being received.
REQ-012 Port: done  output  1  level; high after word LAST_ADDR is written.
REQ-013 Port: checksum  output  16  running sum of written words (see Configuration).

Function
REQ-014 sSCLK, sMOSI, sSS SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized copies only.
REQ-015 Host timing: sSCLK high and low phases each >= 3 clk periods; faster input is unsupported.
REQ-016 FSM states: ARM, IDLE, SHIFT, WRITE, FULL.
REQ-017 ARM: wait for synchronized sSS high, then IDLE.
REQ-018 IDLE: on synchronized sSS low with en=1 -> SHIFT; clear bit counter, addr=0, done=0, checksum=0; with en=0 -> ARM; frame ignored.
REQ-019 SHIFT: each synchronized sSCLK rising edge shifts sMOSI into a 16-bit register LSB side; 4-bit counter increments.
REQ-020 If cycle N detects the 16th edge: cycle N+1 SHALL be WRITE with wen=1, wdata = assembled word, addr = current word address.
REQ-021 Cycle N+2: if addr == LAST_ADDR -> FULL, done=1; else addr increments by 1 and FSM returns to SHIFT.
REQ-022 addr SHALL never wrap; it holds LAST_ADDR in FULL.
REQ-023 FULL: further sSCLK edges ignored, wen stays 0; synchronized sSS high -> IDLE, done held.
REQ-024 Synchronized sSS high in SHIFT: partial word discarded, no write, -> IDLE, done stays 0.
REQ-025 sSS deassert detected in the same cycle as the 16th edge: deassert wins; word discarded, no wen.
REQ-026 sSS deassert while in WRITE: the write completes, then -> IDLE.
REQ-027 en falling mid-frame SHALL NOT abort the frame; en is checked only at frame start.
REQ-028 busy = 1 in SHIFT and WRITE, else 0.
REQ-029 wen SHALL never be high for two consecutive cycles.

Reset
REQ-030 rst low at a clock edge: wen=0, addr=0, wdata=0, busy=0, done=0, checksum=0, shift register and counter cleared, synchronizers cleared to idle (sSCLK 0, sSS 1), FSM=ARM.
REQ-031 Reset mid-frame SHALL abort without any write; reception resumes only after sSS is seen high and then low again.

Configuration
REQ-032 Macro SERIAL_IN_CHECKSUM_EN defined: on every wen pulse, checksum <= checksum + wdata, mod 2^16; cleared at frame start.
REQ-033 Macro undefined: checksum is constant 0 and no adder is synthesized.

Verification
REQ-034 Reset, en=1, frame of words 16'h1234 and 16'hABCD -> wen pulses at addr 0 and 1 with those data; busy=1 until sSS high; done=0.
REQ-035 LAST_ADDR=3, 6 words sent -> 4 writes at addr 0..3; done=1 after 4th; words 5-6 produce no wen; addr holds 3.
REQ-036 sSS deasserted after 9 bits of the second word -> exactly one write, at addr 0; next frame restarts at addr 0.
REQ-037 en=0 at sSS fall, 2 words sent -> no wen, busy=0; en=1 on next frame -> writes from addr 0.
REQ-038 rst low after 7 bits, sSS still low, rst high, 9 more edges -> no wen until sSS goes high and low again.
REQ-039 Macro defined, words 16'hFFFF and 16'h0002 -> checksum 16'h0001; macro undefined -> checksum 0.
